mips_sequencer: RTL and testbench

MIPS_SEQUENCER -- requirements
Module: mips_sequencer

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_sequencer_if.sv | 34 +++
 rtl/mips_busy_counter.sv | 30 +++
 rtl/mips_sequencer.sv | 127 ++++++++++++
 tb/tb_mips_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared sequencer types: state encoding and multiply/divide defaults.
// Combinational only; no latency or backpressure of its own.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC1  = 3'd1,
        ST_EXEC2  = 3'd2,
        ST_MDWAIT = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam int MULDIV_LAT_DEF = 4;
    // Wide enough for the largest legal MULDIV_LAT (255).
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/mips_sequencer_if.sv
// Sequencer bus: decode/handshake inputs and control strobes grouped together.
// master = sequencer side, slave = datapath/memory side.
interface mips_sequencer_if #(
    parameter int CNT_W = 32
);
    logic              waitrequest;
    logic              pc_zero;
    logic              is_load;
    logic              is_store;
    logic              is_muldiv;
    logic              take_branch;
    mips_pkg::state_t  state;
    logic              mem_read;
    logic              mem_write;
    logic              ir_en;
    logic              pc_en;
    logic              reg_we;
    logic              md_start;
    logic              pc_sel_target;
    logic              active;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  waitrequest, pc_zero, is_load, is_store, is_muldiv, take_branch,
        output state, mem_read, mem_write, ir_en, pc_en, reg_we, md_start,
               pc_sel_target, active, retired
    );

    modport slave (
        output waitrequest, pc_zero, is_load, is_store, is_muldiv, take_branch,
        input  state, mem_read, mem_write, ir_en, pc_en, reg_we, md_start,
               pc_sel_target, active, retired
    );
endinterface

// File: rtl/mips_busy_counter.sv
// Mult/div occupancy countdown: load wins over decrement, saturates at zero.
// Flags are registered-state decodes, valid the cycle after a load; no backpressure.
module mips_busy_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_one
);
    logic [W-1:0] r_cnt;
    logic         w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_zero = w_zero;
    assign o_one  = (r_cnt == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_cnt <= r_cnt - W'(1);
        end
    end
endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/EXEC1/EXEC2/MDWAIT/HALT with delay-slot tracking.
// ALU op retires in 2 cycles; memory phases stall while waitrequest is high.
module mips_sequencer
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mips_sequencer_if.master bus
);
    localparam logic [MD_CNT_W-1:0] LAT_M1 = MD_CNT_W'(MULDIV_LAT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_pend;
    logic [CNT_W-1:0] r_retired;
    logic             w_mem_read, w_mem_write, w_ir_en, w_pc_en, w_reg_we, w_md_start;
    logic             w_md_zero, w_md_one, w_md_done;

    mips_busy_counter #(.W(MD_CNT_W)) u_busy (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_md_start),
        .i_load_val (LAT_M1),
        .i_dec      (r_state == ST_MDWAIT),
        .o_zero     (w_md_zero),
        .o_one      (w_md_one)
    );

    // Zero only reachable if something upset the count; exit rather than hang.
    assign w_md_done = w_md_one | w_md_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (bus.pc_zero)          w_next = ST_HALT;
                else if (!bus.waitrequest) w_next = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (bus.is_load) begin
                    if (!bus.waitrequest) w_next = ST_EXEC2;
                end else if (bus.is_store) begin
                    if (!bus.waitrequest) w_next = ST_FETCH;
                end else if (bus.is_muldiv) begin
                    w_next = (MULDIV_LAT == 1) ? ST_FETCH : ST_MDWAIT;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_EXEC2:  w_next = ST_FETCH;
            ST_MDWAIT: if (w_md_done) w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_en     = 1'b0;
        w_pc_en     = 1'b0;
        w_reg_we    = 1'b0;
        w_md_start  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (!bus.pc_zero) begin
                    w_mem_read = 1'b1;
                    w_ir_en    = !bus.waitrequest;
                end
            end
            ST_EXEC1: begin
                if (bus.is_load) begin
                    w_mem_read = 1'b1;
                end else if (bus.is_store) begin
                    w_mem_write = 1'b1;
                    w_pc_en     = !bus.waitrequest;
                end else if (bus.is_muldiv) begin
                    w_md_start = 1'b1;
                    w_pc_en    = (MULDIV_LAT == 1);
                end else begin
                    w_reg_we = 1'b1;
                    w_pc_en  = 1'b1;
                end
            end
            ST_EXEC2: begin
                w_reg_we = 1'b1;
                w_pc_en  = 1'b1;
            end
            ST_MDWAIT: w_pc_en = w_md_done;
            default: ;
        endcase
    end

    // The delay-slot retire consumes the flag, so a branch sitting in the slot cannot re-arm it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_retired <= '0;
        end else if (w_pc_en) begin
            r_retired <= r_retired + CNT_W'(1);
            if (r_pend)
                r_pend <= 1'b0;
            else if (r_state == ST_EXEC1 && bus.take_branch)
                r_pend <= 1'b1;
        end
    end

    // Strobes are masked while reset is held so FETCH does not request memory early.
    assign bus.mem_read      = w_mem_read  & rst_n;
    assign bus.mem_write     = w_mem_write & rst_n;
    assign bus.ir_en         = w_ir_en     & rst_n;
    assign bus.pc_en         = w_pc_en     & rst_n;
    assign bus.reg_we        = w_reg_we    & rst_n;
    assign bus.md_start      = w_md_start  & rst_n;
    assign bus.pc_sel_target = w_pc_en & r_pend & rst_n;
    assign bus.state         = r_state;
    assign bus.active        = (r_state != ST_HALT);
    assign bus.retired       = r_retired;
endmodule

// File: tb/tb_mips_sequencer.sv
// Bench for mips_sequencer: scoreboard of (pc_sel_target, retired) per retire plus per-cycle strobe checks.
// dut_a: MULDIV_LAT=4, CNT_W=4; dut_b: MULDIV_LAT=1, CNT_W=32.
module tb_mips_sequencer;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_na, rst_nb;
    logic waitrequest, pc_zero, is_load, is_store, is_muldiv, take_branch;

    mips_sequencer_if #(.CNT_W(4))  bus_a ();
    mips_sequencer_if #(.CNT_W(32)) bus_b ();

    assign bus_a.waitrequest = waitrequest;
    assign bus_a.pc_zero     = pc_zero;
    assign bus_a.is_load     = is_load;
    assign bus_a.is_store    = is_store;
    assign bus_a.is_muldiv   = is_muldiv;
    assign bus_a.take_branch = take_branch;
    assign bus_b.waitrequest = waitrequest;
    assign bus_b.pc_zero     = pc_zero;
    assign bus_b.is_load     = is_load;
    assign bus_b.is_store    = is_store;
    assign bus_b.is_muldiv   = is_muldiv;
    assign bus_b.take_branch = take_branch;

    mips_sequencer #(.MULDIV_LAT(4), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (bus_a)
    );

    mips_sequencer #(.MULDIV_LAT(1), .CNT_W(32)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       sel;
        logic [3:0] ret;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_cnt;
    logic       m_pend;

    // Expected delay-slot select and pre-retire count for the next instruction issued.
    task automatic push(input bit br);
        exp_t e;
        e.sel = m_pend;
        e.ret = m_cnt;
        sb_q.push_back(e);
        if (m_pend) m_pend = 1'b0;
        else        m_pend = br;
        m_cnt = m_cnt + 4'd1;
    endtask

    always @(negedge clk) begin
        if (rst_na && bus_a.pc_en) begin
            exp_t e;
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("retire_sel", 32'(bus_a.pc_sel_target), 32'(e.sel));
                chk("retire_cnt", 32'(bus_a.retired), 32'(e.ret));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // cls: 0 ALU/branch, 1 load, 2 store, 3 mult/div. fw/ew: waitrequest cycles in FETCH/EXEC1.
    task automatic run_instr(input int cls, input bit br, input int fw, input int ew);
        push(br);
        is_load     = (cls == 1);
        is_store    = (cls == 2);
        is_muldiv   = (cls == 3);
        take_branch = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            waitrequest = (i < fw);
            @(negedge clk);
            chk("f_state", 32'(bus_a.state), 32'(ST_FETCH));
            chk("f_rd", 32'(bus_a.mem_read), 32'd1);
            chk("f_ir", 32'(bus_a.ir_en), 32'(i == fw));
            cyc();
        end
        take_branch = br;
        case (cls)
            0: begin
                waitrequest = 1'b0;
                @(negedge clk);
                chk("alu_state", 32'(bus_a.state), 32'(ST_EXEC1));
                chk("alu_we", 32'(bus_a.reg_we), 32'd1);
                chk("alu_pc", 32'(bus_a.pc_en), 32'd1);
                cyc();
            end
            1: begin
                for (int i = 0; i <= ew; i++) begin
                    waitrequest = (i < ew);
                    @(negedge clk);
                    chk("ld_state", 32'(bus_a.state), 32'(ST_EXEC1));
                    chk("ld_rd", 32'(bus_a.mem_read), 32'd1);
                    chk("ld_pc", 32'(bus_a.pc_en), 32'd0);
                    cyc();
                end
                waitrequest = 1'b0;
                @(negedge clk);
                chk("ld2_state", 32'(bus_a.state), 32'(ST_EXEC2));
                chk("ld2_we", 32'(bus_a.reg_we), 32'd1);
                chk("ld2_pc", 32'(bus_a.pc_en), 32'd1);
                cyc();
            end
            2: begin
                for (int i = 0; i <= ew; i++) begin
                    waitrequest = (i < ew);
                    @(negedge clk);
                    chk("st_state", 32'(bus_a.state), 32'(ST_EXEC1));
                    chk("st_wr", 32'(bus_a.mem_write), 32'd1);
                    chk("st_pc", 32'(bus_a.pc_en), 32'(i == ew));
                    cyc();
                end
            end
            default: begin
                waitrequest = 1'b0;
                @(negedge clk);
                chk("md_state", 32'(bus_a.state), 32'(ST_EXEC1));
                chk("md_start", 32'(bus_a.md_start), 32'd1);
                chk("md_pc", 32'(bus_a.pc_en), 32'd0);
                cyc();
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    chk("mdw_state", 32'(bus_a.state), 32'(ST_MDWAIT));
                    chk("mdw_start", 32'(bus_a.md_start), 32'd0);
                    chk("mdw_pc", 32'(bus_a.pc_en), 32'(k == 3));
                    cyc();
                end
            end
        endcase
        take_branch = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_muldiv   = 1'b0;
        waitrequest = 1'b0;
        chk("retired", 32'(bus_a.retired), 32'(m_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_na = 1'b0; rst_nb = 1'b0;
        waitrequest = 1'b0; pc_zero = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_muldiv = 1'b0; take_branch = 1'b0;
        m_cnt = 4'd0; m_pend = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_state", 32'(bus_a.state), 32'(ST_FETCH));
        chk("rst_active", 32'(bus_a.active), 32'd1);
        chk("rst_retired", 32'(bus_a.retired), 32'd0);
        chk("rst_rd", 32'(bus_a.mem_read), 32'd0);
        cyc();
        rst_na = 1'b1;

        run_instr(0, 1'b0, 0, 0);
        run_instr(1, 1'b0, 0, 3);
        run_instr(1, 1'b0, 2, 0);
        run_instr(2, 1'b0, 0, 2);
        run_instr(3, 1'b0, 0, 0);
        run_instr(0, 1'b1, 0, 0);
        run_instr(0, 1'b0, 0, 0);
        run_instr(0, 1'b0, 1, 0);
        run_instr(0, 1'b1, 0, 0);
        run_instr(0, 1'b1, 0, 0);
        run_instr(0, 1'b0, 0, 0);
        // 11 retired; six more carry the 4-bit counter through 15 -> 0.
        for (int n = 0; n < 6; n++) run_instr(n % 3, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        run_instr(0, 1'b1, 0, 0);
        is_muldiv = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("mid_md_state", 32'(bus_a.state), 32'(ST_MDWAIT));
        #2 rst_na = 1'b0;
        #1;
        chk("arst_state", 32'(bus_a.state), 32'(ST_FETCH));
        chk("arst_active", 32'(bus_a.active), 32'd1);
        chk("arst_retired", 32'(bus_a.retired), 32'd0);
        chk("arst_pc", 32'(bus_a.pc_en), 32'd0);
        is_muldiv = 1'b0;
        m_cnt = 4'd0;
        m_pend = 1'b0;
        cyc();
        cyc();
        rst_na = 1'b1;
        run_instr(0, 1'b0, 0, 0);

        pc_zero = 1'b1;
        @(negedge clk);
        chk("hz_state", 32'(bus_a.state), 32'(ST_FETCH));
        chk("hz_rd", 32'(bus_a.mem_read), 32'd0);
        chk("hz_ir", 32'(bus_a.ir_en), 32'd0);
        cyc();
        pc_zero = 1'b0;
        is_load = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("halt_state", 32'(bus_a.state), 32'(ST_HALT));
            chk("halt_active", 32'(bus_a.active), 32'd0);
            chk("halt_rd", 32'(bus_a.mem_read), 32'd0);
            chk("halt_retired", 32'(bus_a.retired), 32'(m_cnt));
            cyc();
        end
        is_load = 1'b0;
        rst_na = 1'b0;
        #1;
        chk("unhalt_state", 32'(bus_a.state), 32'(ST_FETCH));
        chk("unhalt_active", 32'(bus_a.active), 32'd1);

        cyc();
        rst_nb = 1'b1;
        is_muldiv = 1'b1;
        @(negedge clk);
        chk("b_f_state", 32'(bus_b.state), 32'(ST_FETCH));
        chk("b_f_rd", 32'(bus_b.mem_read), 32'd1);
        cyc();
        @(negedge clk);
        chk("b_md_state", 32'(bus_b.state), 32'(ST_EXEC1));
        chk("b_md_start", 32'(bus_b.md_start), 32'd1);
        chk("b_md_pc", 32'(bus_b.pc_en), 32'd1);
        cyc();
        is_muldiv = 1'b0;
        @(negedge clk);
        chk("b_next_state", 32'(bus_b.state), 32'(ST_FETCH));
        chk("b_md_once", 32'(bus_b.md_start), 32'd0);
        chk("b_retired", bus_b.retired, 32'd1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
